// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory request/acknowledge bus between the fetch stage and the
// instruction memory.
//   ImemReq    fetch request (fetch -> memory)
//   ImemAddr   32-bit fetch address, stable while a request waits
//   ImemAck    data valid this cycle; only meaningful while ImemReq=1
//   ImemRdata  32-bit instruction word returned with ImemAck
// Modports: master = fetch stage, slave = instruction memory.
// -----------------------------------------------------------------------------
interface fetch_stage_if;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic        ImemAck;
   logic [31:0] ImemRdata;

   modport master (
      output ImemReq,
      output ImemAddr,
      input  ImemAck,
      input  ImemRdata
   );

   modport slave (
      input  ImemReq,
      input  ImemAddr,
      output ImemAck,
      output ImemRdata
   );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the program counter (PCF), runs the instruction
// memory handshake and loads the IF/ID pipeline register. Tolerates a
// multi-cycle memory: bubbles on wait states, parks a fetched word while IF is
// stalled, and remembers a redirect that arrives while a fetch is outstanding.
//
// Parameter:
//   RESET_PC   PCF value after reset
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   StallIF           hold PCF and the in-flight fetch
//   StallID           hold the IF/ID register
//   PCSrcD/PCBranchD  taken branch/jump from decode and its target
//   imem              instruction-memory bus (master side)
//   InstrD/PCPlus4D/ValidD  IF/ID register (ValidD=0 is a bubble, InstrD=0)
//
// Build option:
//   FETCH_DELAY_SLOT_EN  when defined, the word fetched at redirect time is
//                        delivered as a delay-slot instruction instead of
//                        being flushed.
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 StallIF,
   input  logic                 StallID,
   input  logic                 PCSrcD,
   input  logic [31:0]          PCBranchD,
   fetch_stage_if.master        imem,
   output logic [31:0]          InstrD,
   output logic [31:0]          PCPlus4D,
   output logic                 ValidD
);

`ifdef FETCH_DELAY_SLOT_EN
   localparam bit DelaySlot = 1'b1;
`else
   localparam bit DelaySlot = 1'b0;
`endif

   typedef enum logic [1:0] {StStart, StReq, StHold} fetchStateT;

   fetchStateT  stateQ, stateNxt;
   logic [31:0] pcfQ, pcfNxt;
   logic [31:0] holdBufQ, holdBufNxt;
   logic [31:0] holdPc4Q, holdPc4Nxt;
   logic        redirPendQ, redirPendNxt;
   logic [31:0] redirPcQ, redirPcNxt;
   logic [31:0] instrNxt, pcPlus4Nxt;
   logic        validNxt;

   logic [31:0] pcPlus4F;
   logic        redirAcc;
   logic        keepWord;

   assign pcPlus4F = pcfQ + 32'd4;
   // A redirect only counts when decode holds a real instruction and advances.
   assign redirAcc = PCSrcD & ValidD & ~StallID;
   // Whether a word returning now is a real instruction or a wrong-path word.
   assign keepWord = DelaySlot | (~redirAcc & ~redirPendQ);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ <= StStart;
      end else begin
         stateQ <= stateNxt;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      stateNxt = stateQ;
      unique case (stateQ)
         StStart: stateNxt = StReq;
         StReq: begin
            if (imem.ImemAck && StallIF && keepWord) begin
               stateNxt = StHold;
            end
         end
         StHold: begin
            if (!StallID) begin
               stateNxt = StReq;
            end
         end
         default: stateNxt = StStart;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      imem.ImemReq  = (stateQ == StReq);
      imem.ImemAddr = pcfQ;
   end

   // ------------------------------------------------------- datapath next-state
   always_comb begin
      pcfNxt       = pcfQ;
      holdBufNxt   = holdBufQ;
      holdPc4Nxt   = holdPc4Q;
      redirPendNxt = redirPendQ;
      redirPcNxt   = redirPcQ;
      instrNxt     = InstrD;
      pcPlus4Nxt   = PCPlus4D;
      validNxt     = ValidD;

      // Decode consumes IF/ID whenever it is not stalled; refill with a bubble
      // unless a word is delivered below.
      if (!StallID) begin
         instrNxt   = '0;
         pcPlus4Nxt = '0;
         validNxt   = 1'b0;
      end

      unique case (stateQ)
         StReq: begin
            if (imem.ImemAck) begin
               if (keepWord) begin
                  if (StallIF) begin
                     holdBufNxt = imem.ImemRdata;
                     holdPc4Nxt = pcPlus4F;
                  end else if (!StallID) begin
                     instrNxt   = imem.ImemRdata;
                     pcPlus4Nxt = pcPlus4F;
                     validNxt   = 1'b1;
                  end
               end
               // Redirects override StallIF on the PC.
               if (redirAcc) begin
                  pcfNxt = PCBranchD;
               end else if (redirPendQ) begin
                  pcfNxt = redirPcQ;
               end else begin
                  pcfNxt = pcPlus4F;
               end
               redirPendNxt = 1'b0;
            end else if (redirAcc) begin
               // Address must stay stable until the memory answers.
               redirPendNxt = 1'b1;
               redirPcNxt   = PCBranchD;
            end
         end
         StHold: begin
            if (!StallID && (DelaySlot || !redirAcc)) begin
               instrNxt   = holdBufQ;
               pcPlus4Nxt = holdPc4Q;
               validNxt   = 1'b1;
            end
            if (redirAcc) begin
               pcfNxt = PCBranchD;
            end
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------ datapath regs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcfQ       <= RESET_PC;
         holdBufQ   <= '0;
         holdPc4Q   <= '0;
         redirPendQ <= 1'b0;
         redirPcQ   <= '0;
         InstrD     <= '0;
         PCPlus4D   <= '0;
         ValidD     <= 1'b0;
      end else begin
         pcfQ       <= pcfNxt;
         holdBufQ   <= holdBufNxt;
         holdPc4Q   <= holdPc4Nxt;
         redirPendQ <= redirPendNxt;
         redirPcQ   <= redirPcNxt;
         InstrD     <= instrNxt;
         PCPlus4D   <= pcPlus4Nxt;
         ValidD     <= validNxt;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage: directed scenarios with fixed expected
// values plus a randomized run against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
   localparam logic [31:0] ResetPc = 32'h0040_0000;
   localparam logic [31:0] Target  = 32'h0040_0100;
`ifdef FETCH_DELAY_SLOT_EN
   localparam bit Ds = 1'b1;
`else
   localparam bit Ds = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        StallIF, StallID, PCSrcD;
   logic [31:0] PCBranchD;
   logic [31:0] InstrD, PCPlus4D;
   logic        ValidD;

   int errors = 0;
   int checks = 0;

   fetch_stage_if imem();

   fetch_stage #(.RESET_PC(ResetPc)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .StallIF   (StallIF),
      .StallID   (StallID),
      .PCSrcD    (PCSrcD),
      .PCBranchD (PCBranchD),
      .imem      (imem),
      .InstrD    (InstrD),
      .PCPlus4D  (PCPlus4D),
      .ValidD    (ValidD)
   );

   always #5 clk = ~clk;

   // Instruction memory contents: a fixed scramble of the address.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   // ---------------------------------------------------------------- ref model
   // Pipeline seen as transactions: a word is either outstanding at mPc, parked
   // in a one-entry queue, or sitting in IF/ID; redirects awaiting an ack wait
   // in redirQ.
   bit          mStarted;
   logic [31:0] mPc, mInstr, mPc4;
   bit          mValid;
   logic [63:0] parkQ[$];
   logic [31:0] redirQ[$];

   task automatic modelReset();
      mStarted = 1'b0;
      mPc      = ResetPc;
      mInstr   = '0;
      mPc4     = '0;
      mValid   = 1'b0;
      parkQ.delete();
      redirQ.delete();
   endtask

   task automatic modelStep(input bit ack, input bit sIF, input bit sID, input bit src,
                            input logic [31:0] tgt);
      bit          taken;
      bit          useful;
      logic [31:0] nInstr, nPc4, w, p4, nextPc;
      bit          nValid;
      taken  = src && mValid && !sID;
      nInstr = sID ? mInstr : 32'h0;
      nPc4   = sID ? mPc4 : 32'h0;
      nValid = sID ? mValid : 1'b0;
      if (!mStarted) begin
         mStarted = 1'b1;
      end else if (parkQ.size() != 0) begin
         if (!sID) begin
            if (Ds || !taken) begin
               nInstr = parkQ[0][63:32];
               nPc4   = parkQ[0][31:0];
               nValid = 1'b1;
            end
            parkQ.delete();
            if (taken) mPc = tgt;
         end
      end else if (ack) begin
         w      = memWord(mPc);
         p4     = mPc + 32'd4;
         useful = Ds || (!taken && redirQ.size() == 0);
         if (taken) nextPc = tgt;
         else if (redirQ.size() != 0) nextPc = redirQ[0];
         else nextPc = p4;
         redirQ.delete();
         if (useful) begin
            if (sIF) parkQ.push_back({w, p4});
            else if (!sID) begin
               nInstr = w;
               nPc4   = p4;
               nValid = 1'b1;
            end
         end
         mPc = nextPc;
      end else if (taken) begin
         redirQ.push_back(tgt);
      end
      mInstr = nInstr;
      mPc4   = nPc4;
      mValid = nValid;
   endtask

   // One clock: drive inputs at the negedge, let the posedge happen, return at
   // the following negedge where outputs are sampled.
   task automatic cycle(input bit ack, input bit sIF, input bit sID, input bit src,
                        input logic [31:0] tgt);
      imem.ImemAck   = ack;
      imem.ImemRdata = ack ? memWord(imem.ImemAddr) : 32'hBAD0_BAD0;
      StallIF        = sIF;
      StallID        = sID;
      PCSrcD         = src;
      PCBranchD      = tgt;
      modelStep(ack, sIF, sID, src, tgt);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic doReset();
      rst_n          = 1'b0;
      imem.ImemAck   = 1'b0;
      imem.ImemRdata = '0;
      StallIF        = 1'b0;
      StallID        = 1'b0;
      PCSrcD         = 1'b0;
      PCBranchD      = '0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
   endtask

   // Reset, then run to the first request at RESET_PC and one delivered word.
   task automatic primeOne();
      doReset();
      cycle(0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
   endtask

   // ---------------------------------------------------------------- scenarios
   task automatic test_reset();
      doReset();
      checks++;
      if (imem.ImemReq !== 1'b0 || imem.ImemAddr !== ResetPc) begin
         errors++;
         $display("FAIL reset_bus got req=%b addr=%h exp req=0 addr=%h",
                  imem.ImemReq, imem.ImemAddr, ResetPc);
      end
      checks++;
      if (ValidD !== 1'b0 || InstrD !== 32'h0 || PCPlus4D !== 32'h0) begin
         errors++;
         $display("FAIL reset_ifid got v=%b i=%h p4=%h exp 0/0/0", ValidD, InstrD, PCPlus4D);
      end
      cycle(0, 0, 0, 0, 0);
      checks++;
      if (imem.ImemReq !== 1'b1 || imem.ImemAddr !== ResetPc) begin
         errors++;
         $display("FAIL first_req got req=%b addr=%h exp req=1 addr=%h",
                  imem.ImemReq, imem.ImemAddr, ResetPc);
      end
   endtask

   task automatic test_stream();
      doReset();
      cycle(0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         logic [31:0] a;
         a = ResetPc + 32'(4 * i);
         cycle(1, 0, 0, 0, 0);
         checks++;
         if (imem.ImemAddr !== a + 32'd4 || ValidD !== 1'b1 || InstrD !== memWord(a) ||
             PCPlus4D !== a + 32'd4) begin
            errors++;
            $display("FAIL stream[%0d] got addr=%h v=%b i=%h p4=%h exp addr=%h v=1 i=%h p4=%h",
                     i, imem.ImemAddr, ValidD, InstrD, PCPlus4D, a + 32'd4, memWord(a),
                     a + 32'd4);
         end
      end
   endtask

   task automatic test_wait();
      primeOne();
      for (int i = 0; i < 2; i++) begin
         cycle(0, 0, 0, 0, 0);
         checks++;
         if (imem.ImemReq !== 1'b1 || imem.ImemAddr !== 32'h0040_0004 || ValidD !== 1'b0) begin
            errors++;
            $display("FAIL wait[%0d] got req=%b addr=%h v=%b exp req=1 addr=00400004 v=0",
                     i, imem.ImemReq, imem.ImemAddr, ValidD);
         end
      end
      cycle(1, 0, 0, 0, 0);
      checks++;
      if (ValidD !== 1'b1 || InstrD !== memWord(32'h0040_0004) ||
          imem.ImemAddr !== 32'h0040_0008) begin
         errors++;
         $display("FAIL wait_deliver got v=%b i=%h addr=%h exp v=1 i=%h addr=00400008",
                  ValidD, InstrD, imem.ImemAddr, memWord(32'h0040_0004));
      end
   endtask

   task automatic test_stall_hold();
      primeOne();
      cycle(1, 1, 1, 0, 0);
      cycle(0, 1, 1, 0, 0);
      checks++;
      if (imem.ImemReq !== 1'b0 || InstrD !== memWord(ResetPc) ||
          PCPlus4D !== 32'h0040_0004 || ValidD !== 1'b1) begin
         errors++;
         $display("FAIL hold_frozen got req=%b i=%h p4=%h v=%b exp req=0 i=%h p4=00400004 v=1",
                  imem.ImemReq, InstrD, PCPlus4D, ValidD, memWord(ResetPc));
      end
      cycle(0, 0, 0, 0, 0);
      checks++;
      if (ValidD !== 1'b1 || InstrD !== memWord(32'h0040_0004) ||
          PCPlus4D !== 32'h0040_0008 || imem.ImemReq !== 1'b1 ||
          imem.ImemAddr !== 32'h0040_0008) begin
         errors++;
         $display("FAIL hold_release got v=%b i=%h p4=%h req=%b addr=%h exp v=1 i=%h p4=00400008 req=1 addr=00400008",
                  ValidD, InstrD, PCPlus4D, imem.ImemReq, imem.ImemAddr,
                  memWord(32'h0040_0004));
      end
   endtask

   task automatic test_redirect_ack();
      primeOne();
      cycle(1, 0, 0, 1, Target);
      checks++;
      if (imem.ImemAddr !== Target || ValidD !== Ds ||
          (Ds && InstrD !== memWord(32'h0040_0004))) begin
         errors++;
         $display("FAIL redir_ack got addr=%h v=%b i=%h exp addr=%h v=%b",
                  imem.ImemAddr, ValidD, InstrD, Target, Ds);
      end
      cycle(1, 0, 0, 0, 0);
      checks++;
      if (ValidD !== 1'b1 || InstrD !== memWord(Target) || imem.ImemAddr !== Target + 32'd4) begin
         errors++;
         $display("FAIL redir_target got v=%b i=%h addr=%h exp v=1 i=%h addr=%h",
                  ValidD, InstrD, imem.ImemAddr, memWord(Target), Target + 32'd4);
      end
   endtask

   task automatic test_redirect_wait();
      primeOne();
      cycle(0, 0, 0, 1, Target);
      for (int i = 0; i < 3; i++) begin
         if (i != 0) cycle(0, 0, 0, 0, 0);
         checks++;
         if (imem.ImemAddr !== 32'h0040_0004 || imem.ImemReq !== 1'b1 || ValidD !== 1'b0) begin
            errors++;
            $display("FAIL redir_wait[%0d] got addr=%h req=%b v=%b exp addr=00400004 req=1 v=0",
                     i, imem.ImemAddr, imem.ImemReq, ValidD);
         end
      end
      cycle(1, 0, 0, 0, 0);
      checks++;
      if (imem.ImemAddr !== Target || ValidD !== Ds ||
          (Ds && InstrD !== memWord(32'h0040_0004))) begin
         errors++;
         $display("FAIL redir_wait_ack got addr=%h v=%b i=%h exp addr=%h v=%b",
                  imem.ImemAddr, ValidD, InstrD, Target, Ds);
      end
   endtask

   task automatic test_wrap();
      primeOne();
      cycle(1, 0, 0, 1, 32'hFFFF_FFFC);
      cycle(1, 0, 0, 0, 0);
      checks++;
      if (imem.ImemAddr !== 32'h0 || PCPlus4D !== 32'h0 || ValidD !== 1'b1 ||
          InstrD !== memWord(32'hFFFF_FFFC)) begin
         errors++;
         $display("FAIL wrap got addr=%h p4=%h v=%b i=%h exp addr=0 p4=0 v=1 i=%h",
                  imem.ImemAddr, PCPlus4D, ValidD, InstrD, memWord(32'hFFFF_FFFC));
      end
   endtask

   task automatic test_reset_midwait();
      primeOne();
      cycle(0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      checks++;
      if (imem.ImemReq !== 1'b0 || ValidD !== 1'b0 || imem.ImemAddr !== ResetPc) begin
         errors++;
         $display("FAIL midwait_reset got req=%b v=%b addr=%h exp req=0 v=0 addr=%h",
                  imem.ImemReq, ValidD, imem.ImemAddr, ResetPc);
      end
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      cycle(0, 0, 0, 0, 0);
      checks++;
      if (imem.ImemReq !== 1'b1 || imem.ImemAddr !== ResetPc) begin
         errors++;
         $display("FAIL midwait_restart got req=%b addr=%h exp req=1 addr=%h",
                  imem.ImemReq, imem.ImemAddr, ResetPc);
      end
   endtask

   task automatic test_random();
      doReset();
      for (int n = 0; n < 800; n++) begin
         bit          ack, sIF, sID, src;
         logic [31:0] tgt;
         bit          expReq;
         ack = ($urandom_range(0, 9) < 6);
         sIF = ($urandom_range(0, 9) < 2);
         sID = sIF && ($urandom_range(0, 1) == 1);
         src = ($urandom_range(0, 9) < 2);
         tgt = ResetPc + {20'h0, 8'($urandom_range(0, 255)), 4'h0};
         cycle(ack, sIF, sID, src, tgt);
         expReq = mStarted && (parkQ.size() == 0);
         checks++;
         if (imem.ImemReq !== expReq || imem.ImemAddr !== mPc || ValidD !== mValid) begin
            errors++;
            $display("FAIL rand_bus[%0d] got req=%b addr=%h v=%b exp req=%b addr=%h v=%b",
                     n, imem.ImemReq, imem.ImemAddr, ValidD, expReq, mPc, mValid);
         end
         if (mValid) begin
            checks++;
            if (InstrD !== mInstr || PCPlus4D !== mPc4) begin
               errors++;
               $display("FAIL rand_ifid[%0d] got i=%h p4=%h exp i=%h p4=%h",
                        n, InstrD, PCPlus4D, mInstr, mPc4);
            end
         end
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      imem.ImemAck   = 1'b0;
      imem.ImemRdata = '0;
      StallIF        = 1'b0;
      StallID        = 1'b0;
      PCSrcD         = 1'b0;
      PCBranchD      = '0;
      modelReset();
      @(negedge clk);
      test_reset();
      test_stream();
      test_wait();
      test_stall_hold();
      test_redirect_ack();
      test_redirect_wait();
      test_wrap();
      test_reset_midwait();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipeline: owns the program counter (PCF), drives the instruction-memory request/acknowledge handshake, and loads the IF/ID pipeline register (InstrD, PCPlus4D, ValidD). It sits directly upstream of decode and consumes the hazard unit's StallIF/StallID plus decode's branch resolution (PCSrcD/PCBranchD). It tolerates a multi-cycle instruction memory: it inserts bubbles on wait states, parks a fetched word while stalled, and tracks redirects that arrive while a fetch is outstanding.

## Interface
- RESET_PC, 32'h0000_0000, PCF value after reset.
- clk  input  1  pipeline clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- StallIF  input  1  hazard unit: hold PCF and the in-flight fetch.
- StallID  input  1  hazard unit: hold IF/ID register.
- PCSrcD  input  1  decode: taken branch/jump; honoured only when ValidD=1 and StallID=0.
- PCBranchD  input  32  redirect target.
- ImemReq  output  1  fetch request.
- ImemAddr  output  32  fetch address (= PCF).
- ImemAck  input  1  data valid this cycle; only meaningful while ImemReq=1.
- ImemRdata  input  32  instruction word.
- InstrD  output  32  IF/ID instruction.
- PCPlus4D  output  32  IF/ID PC+4.
- ValidD  output  1  IF/ID holds a real instruction (0 = bubble, InstrD=0).

## Operation
- Registers: PCF, state, HoldBuf (32b) + HoldPC4, RedirPending + RedirPC, IF/ID {InstrD, PCPlus4D, ValidD}.
- States: START (after reset, ImemReq=0) -> REQ unconditionally next edge; REQ (ImemReq=1); HOLD (word parked in HoldBuf, ImemReq=0).
- REQ & ImemAck & !StallIF: word completes; if !StallID load IF/ID {ImemRdata, PCF+4, 1}; PCF <= RedirPending ? RedirPC : PCF+4; clear RedirPending.
- REQ & ImemAck & StallIF: capture ImemRdata/PCF+4 into HoldBuf, PCF advances as above, go HOLD.
- REQ & !ImemAck: ImemAddr held stable; IF/ID loads bubble if !StallID, else holds.
- HOLD & !StallID: move HoldBuf into IF/ID (ValidD=1), go REQ. HOLD & StallID: everything holds.
- Accepted redirect (PCSrcD & ValidD & !StallID), delay slot off:
  - REQ with ack same cycle: discard ImemRdata, IF/ID bubble, PCF <= PCBranchD.
  - REQ without ack: IF/ID bubble, RedirPending=1, RedirPC=PCBranchD; outstanding access finishes at old address, its data discarded (no IF/ID load, no HOLD).
  - HOLD: HoldBuf discarded, IF/ID bubble, PCF <= PCBranchD, go REQ.
- PCF arithmetic: 32-bit, PC+4 wraps modulo 2^32; bits [1:0] passed unchecked.
- Redirect has priority over stall on PCF update; StallID=1 blocks redirect acceptance entirely.

## Timing
- Reset (async, immediate): PCF=RESET_PC, ImemAddr=RESET_PC, ImemReq=0, state=START, InstrD=0, PCPlus4D=0, ValidD=0, RedirPending=0, HoldBuf=0.
- First ImemReq=1 one cycle after rst_n rises.
- Ack in cycle N -> InstrD visible cycle N+1; next ImemAddr visible N+1. ImemAck tied high gives one instruction per cycle.
- Redirect accepted cycle N with ack -> ImemAddr=PCBranchD in N+1 (delay slot off).
- Reset asserted mid-wait: request dropped immediately; memory must discard the transaction.

## Configuration
- FETCH_DELAY_SLOT_EN defined: MIPS delay slot. The word fetched at redirect time is delivered (ValidD=1) instead of discarded; in REQ-without-ack and HOLD cases it completes/parks and is delivered normally, then PCF=RedirPC. IF/ID never bubbles because of a redirect.
- Undefined: flush-on-taken behaviour described under Operation.

## Test plan
- RESET_PC=0x0040_0000, ImemAck=1 -> ImemAddr 0x400000, 0x400004, 0x400008 on consecutive cycles; InstrD/PCPlus4D one cycle later, ValidD=1.
- Ack two cycles after request -> ImemAddr stable 0x400004 for 3 cycles, ValidD=0 for 2 cycles, then word delivered.
- StallIF=StallID=1 for 2 cycles at an ack -> InstrD/PCPlus4D frozen, ImemReq=0 in HOLD, parked word appears first cycle after release, ImemAddr continues at next PC.
- PCSrcD=1, PCBranchD=0x0040_0100, ack same cycle, macro off -> ValidD=0 next cycle, ImemAddr=0x400100; macro on -> delay-slot word with ValidD=1, then 0x400100.
- Redirect during 3-cycle wait, macro off -> old address held until ack, data dropped (ValidD stays 0), then ImemAddr=0x400100.
- rst_n pulsed low mid-wait -> ImemReq=0 and ValidD=0 same cycle; START then REQ at 0x0040_0000.
